// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and default timing constants for button conditioning.
package btn_pkg;

    typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} btn_state_t;

    localparam int BTN_STABLE_DEFAULT        = 1000000;
    localparam int BTN_REPEAT_DELAY_DEFAULT  = 25000000;
    localparam int BTN_REPEAT_PERIOD_DEFAULT = 5000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with asynchronous active-low reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge reset)
        if (!reset) {q, m} <= 2'b00;
        else        {q, m} <= {m, d};
endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronize, debounce and edge-detect a raw button input.
// Define BTN_REPEAT_EN to add auto-repeat press pulses while the button is held.
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = BTN_STABLE_DEFAULT,
    parameter int REPEAT_DELAY  = BTN_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = BTN_REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int CW = $clog2(max3(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CW-1:0] S_LAST = CW'(STABLE_CYCLES - 1);

    logic           sync_q;
    btn_state_t     state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;

    sync2 u_sync (.clk(clk), .reset(reset), .d(btn_in), .q(sync_q));

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

`ifdef BTN_REPEAT_EN
    localparam logic [CW-1:0] D_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] P_LAST = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0]  rpt_cnt;
    logic [CW-1:0]  rpt_inc;
    logic           rpt_first;
    logic           rpt_fire;
    assign rpt_inc  = (&rpt_cnt) ? rpt_cnt : rpt_cnt + 1'b1;
    // first repeat waits the full delay, later ones only the period
    assign rpt_fire = rpt_cnt == (rpt_first ? D_LAST : P_LAST);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RELEASED;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BTN_REPEAT_EN
            rpt_cnt       <= '0;
            rpt_first     <= 1'b1;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BTN_REPEAT_EN
            rpt_cnt       <= '0;
            rpt_first     <= 1'b1;
`endif
            case (state)
                RELEASED:
                    if (sync_q) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                PRESS_CHK:
                    if (!sync_q) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == S_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else
                        cnt <= cnt_inc;
                PRESSED:
                    if (!sync_q) begin
                        state <= RELEASE_CHK;
                        cnt   <= '0;
                    end
`ifdef BTN_REPEAT_EN
                    else if (rpt_fire) begin
                        press_pulse <= 1'b1;
                        rpt_first   <= 1'b0;
                    end else begin
                        rpt_cnt   <= rpt_inc;
                        rpt_first <= rpt_first;
                    end
`endif
                RELEASE_CHK:
                    if (sync_q) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == S_LAST) begin
                        state         <= RELEASED;
                        cnt           <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else
                        cnt <= cnt_inc;
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule
